// File: rtl/motor_pwm_ctrl.sv
// motor_pwm_ctrl: NUM_CH identical H-bridge channels sharing one PWM timebase.
// Each channel ramps its duty toward the commanded target once per PWM period.
// It ramps down to zero and inserts dead-time before any reversal.
// It drives both bridge inputs high for active braking.
module motor_pwm_ctrl #(
    parameter int NUM_CH    = 2,
    parameter int PWM_W     = 8,
    parameter int PRESCALE  = 4,
    parameter int RAMP_STEP = 8,
    parameter int DEADTIME  = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [PWM_W-1:0]  cmd_duty,
    input  logic              cmd_dir,
    input  logic              cmd_brake,
    output logic              cmd_err,
    output logic [NUM_CH-1:0] pwm,
    output logic [NUM_CH-1:0] fwd,
    output logic [NUM_CH-1:0] bwd,
    output logic [NUM_CH-1:0] at_target
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [PWM_W-1:0] STEP      = PWM_W'(RAMP_STEP);
    localparam logic [DT_W-1:0]  DEAD_LOAD = DT_W'(DEADTIME - 1);

    typedef enum logic [1:0] {COAST, RUN, DEAD, BRAKE} state_t;

    // Shared timebase
    logic [PS_W-1:0]  presc;
    logic [PWM_W-1:0] cnt;
    logic             tick;
    logic             pb;

    // Command decode
    logic              accept;
    logic              ch_ok;
    logic [NUM_CH-1:0] hit;

    // Per-channel state
    state_t            state_q    [NUM_CH];
    state_t            state_d    [NUM_CH];
    logic [PWM_W-1:0]  duty_q     [NUM_CH];
    logic [PWM_W-1:0]  duty_d     [NUM_CH];
    logic [PWM_W-1:0]  tgt_duty_q [NUM_CH];
    logic [DT_W-1:0]   dead_q     [NUM_CH];
    logic [DT_W-1:0]   dead_d     [NUM_CH];
    logic [NUM_CH-1:0] dir_q;
    logic [NUM_CH-1:0] dir_d;
    logic [NUM_CH-1:0] tgt_dir_q;
    logic [NUM_CH-1:0] brk_req_q;
    logic [NUM_CH-1:0] go_req_q;
    logic [NUM_CH-1:0] pwm_raw;

    assign tick   = (presc == PS_W'(PRESCALE - 1));
    assign pb     = tick && (cnt == {PWM_W{1'b1}});
    assign accept = cmd_valid && cmd_ready;
    assign ch_ok  = (int'(cmd_ch) < NUM_CH);

    // One ramp step toward goal, clamped so it never overshoots.
    function automatic logic [PWM_W-1:0] ramp(input logic [PWM_W-1:0] cur,
                                              input logic [PWM_W-1:0] goal);
        if (cur < goal) begin
            if ((goal - cur) > STEP) return cur + STEP;
            return goal;
        end
        if ((cur - goal) > STEP) return cur - STEP;
        return goal;
    endfunction

    // One-hot selection of the channel addressed by an accepted, in-range command.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = accept && ch_ok && (int'(cmd_ch) == i);
        end
    end

    // Prescaler, PWM counter and command handshake flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc     <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            presc     <= tick ? '0 : presc + 1'b1;
            if (tick) cnt <= cnt + 1'b1;
            cmd_ready <= 1'b1;
            cmd_err   <= accept && !ch_ok;
        end
    end

    // Next-state logic per channel: brake request overrides everything.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every output of this block gets a default first; a branch that
            // skipped one would otherwise infer a latch.
            state_d[i] = state_q[i];
            duty_d[i]  = duty_q[i];
            dir_d[i]   = dir_q[i];
            dead_d[i]  = dead_q[i];
            if (brk_req_q[i]) begin
                state_d[i] = BRAKE;
                duty_d[i]  = '0;
            end else begin
                case (state_q[i])
                    COAST: if (tgt_duty_q[i] != '0) begin
                        state_d[i] = RUN;
                        dir_d[i]   = tgt_dir_q[i];
                        duty_d[i]  = '0;
                    end
                    BRAKE: if (go_req_q[i]) begin
                        state_d[i] = DEAD;
                        dead_d[i]  = DEAD_LOAD;
                    end
                    DEAD: if (dead_q[i] == '0) begin
                        dir_d[i]   = tgt_dir_q[i];
                        state_d[i] = (tgt_duty_q[i] != '0) ? RUN : COAST;
                    end else begin
                        dead_d[i]  = dead_q[i] - 1'b1;
                    end
                    RUN: if (pb) begin
                        if (tgt_dir_q[i] != dir_q[i]) begin
                            // Reversal pending: ramp to zero, then open the bridge.
                            if (duty_q[i] == '0) begin
                                state_d[i] = DEAD;
                                dead_d[i]  = DEAD_LOAD;
                            end else begin
                                duty_d[i]  = ramp(duty_q[i], {PWM_W{1'b0}});
                            end
                        end else if (duty_q[i] == '0 && tgt_duty_q[i] == '0) begin
                            state_d[i] = COAST;
                        end else begin
                            duty_d[i]  = ramp(duty_q[i], tgt_duty_q[i]);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Channel registers: state, duty, direction, targets, dead counter, request flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: these per-channel arrays are a handful of flops, not RAM, so they
            // take an explicit reset like any other register.
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]    <= COAST;
                duty_q[i]     <= '0;
                tgt_duty_q[i] <= '0;
                dead_q[i]     <= '0;
            end
            dir_q     <= '0;
            tgt_dir_q <= '0;
            brk_req_q <= '0;
            go_req_q  <= '0;
            pwm_raw   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values,
            // so a same-cycle command cannot disturb the ramp step it coincides with.
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                duty_q[i]  <= duty_d[i];
                dead_q[i]  <= dead_d[i];
                pwm_raw[i] <= (duty_q[i] > cnt);
                brk_req_q[i] <= hit[i] && cmd_brake;
                go_req_q[i]  <= hit[i] && !cmd_brake;
                if (hit[i] && !cmd_brake) begin
                    tgt_duty_q[i] <= cmd_duty;
                    tgt_dir_q[i]  <= cmd_dir;
                end
            end
            dir_q <= dir_d;
        end
    end

    // Bridge and status outputs decoded from the registered channel state.
    always_comb begin
        pwm       = '0;
        fwd       = '0;
        bwd       = '0;
        at_target = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm[i]       = pwm_raw[i] && (state_q[i] == RUN);
            fwd[i]       = (state_q[i] == RUN && !dir_q[i]) || (state_q[i] == BRAKE);
            bwd[i]       = (state_q[i] == RUN &&  dir_q[i]) || (state_q[i] == BRAKE);
            at_target[i] = (duty_q[i] == tgt_duty_q[i]) &&
                           (state_q[i] == RUN || state_q[i] == COAST);
        end
    end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Scoreboard bench for motor_pwm_ctrl: a time-based reference model predicts
// every cycle's outputs into a queue, and a monitor compares them against the DUT.
module tb_motor_pwm_ctrl;

    localparam int NUM_CH    = 3;
    localparam int PWM_W     = 4;
    localparam int PRESCALE  = 2;
    localparam int RAMP_STEP = 4;
    localparam int DEADTIME  = 3;
    localparam int CH_W      = $clog2(NUM_CH);
    localparam int CNT_MOD   = 1 << PWM_W;
    localparam int PERIOD    = PRESCALE * CNT_MOD;

    logic              clock     = 1'b0;
    logic              reset     = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [CH_W-1:0]   cmd_ch    = '0;
    logic [PWM_W-1:0]  cmd_duty  = '0;
    logic              cmd_dir   = 1'b0;
    logic              cmd_brake = 1'b0;
    logic              cmd_ready;
    logic              cmd_err;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] fwd;
    logic [NUM_CH-1:0] bwd;
    logic [NUM_CH-1:0] at_target;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    motor_pwm_ctrl #(
        .NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRESCALE(PRESCALE),
        .RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .cmd_brake(cmd_brake),
        .cmd_err(cmd_err), .pwm(pwm), .fwd(fwd), .bwd(bwd), .at_target(at_target)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NUM_CH-1:0] pwm;
        logic [NUM_CH-1:0] fwd;
        logic [NUM_CH-1:0] bwd;
        logic [NUM_CH-1:0] at_target;
        logic              ready;
        logic              err;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_COAST, M_RUN, M_DEAD, M_BRAKE} mstate_e;

    mstate_e m_st        [NUM_CH];
    int      m_duty      [NUM_CH];
    int      m_tgt       [NUM_CH];
    int      m_dir       [NUM_CH];
    int      m_tdir      [NUM_CH];
    int      m_dead_exit [NUM_CH];
    bit      m_brk       [NUM_CH];
    bit      m_go        [NUM_CH];
    bit      m_raw       [NUM_CH];
    bit      m_ready;
    bit      m_err;
    int      n_edges;

    // Time-based model: the PWM count and period boundaries are pure functions of
    // the number of clock edges since reset; dead-time is an absolute exit edge.
    always @(posedge clock) begin : ref_model
        exp_t e;
        bit   pb;
        bit   acc;
        int   cnt_now;
        int   edge_no;
        int   goal;
        int   diff;
        if (reset) begin
            n_edges = 0;
            m_ready = 1'b0;
            m_err   = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_st[c] = M_COAST; m_duty[c] = 0; m_tgt[c] = 0; m_dir[c] = 0;
                m_tdir[c] = 0; m_dead_exit[c] = 0; m_brk[c] = 0; m_go[c] = 0; m_raw[c] = 0;
            end
        end else begin
            pb      = (n_edges % PERIOD) == PERIOD - 1;
            cnt_now = (n_edges / PRESCALE) % CNT_MOD;
            acc     = cmd_valid && m_ready;
            edge_no = n_edges + 1;
            for (int c = 0; c < NUM_CH; c++) begin
                m_raw[c] = m_duty[c] > cnt_now;
                if (m_brk[c]) begin
                    m_st[c] = M_BRAKE;
                    m_duty[c] = 0;
                end else begin
                    case (m_st[c])
                        M_COAST: if (m_tgt[c] > 0) begin
                            m_st[c] = M_RUN; m_dir[c] = m_tdir[c]; m_duty[c] = 0;
                        end
                        M_BRAKE: if (m_go[c]) begin
                            m_st[c] = M_DEAD; m_dead_exit[c] = edge_no + DEADTIME;
                        end
                        M_DEAD: if (edge_no >= m_dead_exit[c]) begin
                            m_dir[c] = m_tdir[c];
                            m_st[c]  = (m_tgt[c] > 0) ? M_RUN : M_COAST;
                        end
                        M_RUN: if (pb) begin
                            goal = (m_tdir[c] != m_dir[c]) ? 0 : m_tgt[c];
                            diff = goal - m_duty[c];
                            if (diff == 0) begin
                                if (m_tdir[c] != m_dir[c]) begin
                                    m_st[c] = M_DEAD; m_dead_exit[c] = edge_no + DEADTIME;
                                end else if (goal == 0) begin
                                    m_st[c] = M_COAST;
                                end
                            end else if (diff > RAMP_STEP) m_duty[c] += RAMP_STEP;
                            else if (diff < -RAMP_STEP)    m_duty[c] -= RAMP_STEP;
                            else                           m_duty[c] = goal;
                        end
                        default: ;
                    endcase
                end
                m_brk[c] = 1'b0;
                m_go[c]  = 1'b0;
            end
            if (acc && int'(cmd_ch) < NUM_CH) begin
                if (cmd_brake) m_brk[cmd_ch] = 1'b1;
                else begin
                    m_go[cmd_ch]   = 1'b1;
                    m_tgt[cmd_ch]  = int'(cmd_duty);
                    m_tdir[cmd_ch] = int'(cmd_dir);
                end
            end
            m_err   = acc && int'(cmd_ch) >= NUM_CH;
            m_ready = 1'b1;
            n_edges++;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            e.pwm[c]       = m_raw[c] && m_st[c] == M_RUN;
            e.fwd[c]       = (m_st[c] == M_RUN) ? (m_dir[c] == 0) : (m_st[c] == M_BRAKE);
            e.bwd[c]       = (m_st[c] == M_RUN) ? (m_dir[c] == 1) : (m_st[c] == M_BRAKE);
            e.at_target[c] = (m_duty[c] == m_tgt[c]) && (m_st[c] == M_RUN || m_st[c] == M_COAST);
        end
        e.ready = m_ready;
        e.err   = m_err;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            check("scoreboard_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cmd_ready", cmd_ready, e.ready);
                check("cmd_err",   cmd_err,   e.err);
                check("pwm",       pwm,       e.pwm);
                check("fwd",       fwd,       e.fwd);
                check("bwd",       bwd,       e.bwd);
                check("at_target", at_target, e.at_target);
            end
        end
    end

    always @(negedge clock) if (cmd_err === 1'b1) err_seen++;

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clock);
    endtask

    // Holds a command for exactly one edge; consecutive calls are back-to-back.
    task automatic send(input logic [CH_W-1:0] ch, input logic [PWM_W-1:0] duty,
                        input logic dir, input logic brake);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_duty  = duty;
        cmd_dir   = dir;
        cmd_brake = brake;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    initial begin : stimulus
        int highs;
        int dead_cnt;
        int err_before;

        // Reset held for three edges.
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(4);

        // Soft start on ch0, then measure steady-state duty over one period.
        send(CH_W'(0), PWM_W'(10), 1'b0, 1'b0);
        wait_cycles(160);
        highs = 0;
        repeat (PERIOD) begin
            @(negedge clock);
            if (pwm[0] === 1'b1) highs++;
        end
        check("pwm0_duty10_highs", highs, 20);

        // Reversal from duty 8 forward to duty 6 back: exactly DEADTIME open clocks.
        send(CH_W'(0), PWM_W'(8), 1'b0, 1'b0);
        wait_cycles(100);
        send(CH_W'(0), PWM_W'(6), 1'b1, 1'b0);
        dead_cnt = 0;
        repeat (150) begin
            @(negedge clock);
            if (fwd[0] === 1'b0 && bwd[0] === 1'b0) dead_cnt++;
        end
        check("reversal_dead_clocks", dead_cnt, DEADTIME);
        wait_cycles(80);

        // Brake ch1 at duty 12, then release to duty 5 forward.
        send(CH_W'(1), PWM_W'(12), 1'b0, 1'b0);
        wait_cycles(140);
        send(CH_W'(1), PWM_W'(0), 1'b0, 1'b1);
        wait_cycles(5);
        send(CH_W'(1), PWM_W'(5), 1'b0, 1'b0);
        dead_cnt = 0;
        repeat (60) begin
            @(negedge clock);
            if (fwd[1] === 1'b0 && bwd[1] === 1'b0) dead_cnt++;
        end
        check("brake_release_dead_clocks", dead_cnt, DEADTIME);
        wait_cycles(100);

        // Out-of-range channel: single error pulse.
        err_before = err_seen;
        send(CH_W'(3), PWM_W'(9), 1'b1, 1'b0);
        wait_cycles(5);
        check("invalid_ch_err_pulses", err_seen - err_before, 1);

        // Retarget twice while ch0 sits in DEAD: the last command wins.
        send(CH_W'(0), PWM_W'(0), 1'b0, 1'b1);
        wait_cycles(3);
        send(CH_W'(0), PWM_W'(9), 1'b1, 1'b0);
        wait_cycles(1);
        send(CH_W'(0), PWM_W'(3), 1'b0, 1'b0);
        send(CH_W'(0), PWM_W'(7), 1'b1, 1'b0);
        wait_cycles(120);
        check("retarget_bwd0", bwd[0], 1'b1);
        check("retarget_fwd0", fwd[0], 1'b0);
        check("retarget_at_target0", at_target[0], 1'b1);

        // Reset in the middle of operation.
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(3);

        // Randomized command traffic, including brakes and invalid channels.
        repeat (1500) begin
            if ($urandom_range(0, 11) == 0) begin
                send(CH_W'($urandom_range(0, 3)), PWM_W'($urandom_range(0, CNT_MOD - 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            end else begin
                @(negedge clock);
            end
        end

        wait_cycles(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
